// File: rtl/cpu_pkg.sv
// Shared definitions for the WISC hazard/stall controller:
// FSM state codes, memory-port owner codes, register-zero constant.
package cpu_pkg;

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_I_FILL = 2'b01;
    localparam logic [1:0] ST_D_FILL = 2'b10;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

    localparam logic [3:0] REG_ZERO = 4'h0;

    typedef enum logic [1:0] {
        S_RUN    = ST_RUN,
        S_I_FILL = ST_I_FILL,
        S_D_FILL = ST_D_FILL
    } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Main-memory fill port shared by the I-cache and D-cache.
// The controller is master: it requests and selects, memory answers done.
interface hazard_stall_ctrl_if;

    logic fill_req;
    logic fill_sel;
    logic fill_done;

    modport master (
        output fill_req,
        output fill_sel,
        input  fill_done
    );

    modport slave (
        input  fill_req,
        input  fill_sel,
        output fill_done
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // count up on inc, stop at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use detection, stage enables/flushes and serialisation of
// I/D cache fills onto the single memory port, plus perf counters.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           D_Rs,
    input  logic [3:0]           D_Rt,
    input  logic                 D_usesRs,
    input  logic                 D_usesRt,
    input  logic                 D_memWrite,
    input  logic                 X_memRead,
    input  logic [3:0]           X_Rd,
    input  logic                 X_branchTaken,
    input  logic                 icache_miss,
    input  logic                 dcache_miss,
    hazard_stall_ctrl_if.master  mem,
    output logic                 pc_write,
    output logic                 IFID_write,
    output logic                 IDEX_write,
    output logic                 XM_write,
    output logic                 IFID_flush,
    output logic                 IDEX_flush,
    output logic                 MW_flush,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    state_t r_state;
    state_t w_next;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_lu;
    logic w_fill_req;
    logic w_fill_sel;
    logic w_stall_inc;
    logic w_flush_inc;

    // Rt feeding a store's data is covered by MEM-MEM forwarding
    assign w_rs_hit = D_usesRs && (X_Rd == D_Rs);
    assign w_rt_hit = D_usesRt && (X_Rd == D_Rt) && !D_memWrite;
    assign w_lu     = X_memRead && (X_Rd != REG_ZERO)
                   && (w_rs_hit || w_rt_hit);

    // state register; reset abandons any grant in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and Mealy stage controls
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b1;
        IFID_write = 1'b1;
        IDEX_write = 1'b1;
        XM_write   = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        MW_flush   = 1'b0;
        w_fill_req = 1'b0;
        w_fill_sel = FILL_SEL_I;

        unique case (r_state)
            S_RUN: begin
                if (dcache_miss) begin
                    w_next = S_D_FILL;
                end else if (icache_miss) begin
                    w_next = S_I_FILL;
                end

                if (dcache_miss) begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_write = 1'b0;
                    XM_write   = 1'b0;
                    MW_flush   = 1'b1;
                end else if (X_branchTaken) begin
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                end else if (w_lu) begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_flush = 1'b1;
                end else if (icache_miss) begin
                    pc_write   = 1'b0;
                    IFID_flush = 1'b1;
                end
            end

            S_D_FILL: begin
                w_fill_req = 1'b1;
                w_fill_sel = FILL_SEL_D;
                pc_write   = 1'b0;
                IFID_write = 1'b0;
                IDEX_write = 1'b0;
                XM_write   = 1'b0;
                MW_flush   = 1'b1;
                if (mem.fill_done) begin
                    w_next = icache_miss ? S_I_FILL : S_RUN;
                end
            end

            S_I_FILL: begin
                w_fill_req = 1'b1;
                w_fill_sel = FILL_SEL_I;
                if (dcache_miss) begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_write = 1'b0;
                    XM_write   = 1'b0;
                    MW_flush   = 1'b1;
                end else if (X_branchTaken) begin
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                end else begin
                    pc_write   = 1'b0;
                    IFID_flush = 1'b1;
                end
                if (mem.fill_done) begin
                    w_next = dcache_miss ? S_D_FILL : S_RUN;
                end
            end

            default: begin
                w_next = S_RUN;
            end
        endcase

        if (rst) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_write = 1'b0;
            XM_write   = 1'b0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            MW_flush   = 1'b1;
            w_fill_req = 1'b0;
            w_fill_sel = FILL_SEL_I;
        end
    end

    assign mem.fill_req = w_fill_req;
    assign mem.fill_sel = w_fill_sel;

    assign w_stall_inc = !pc_write;
    assign w_flush_inc = IFID_flush || IDEX_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: rule-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hazard_stall_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [3:0]    D_Rs, D_Rt, X_Rd;
    logic          D_usesRs, D_usesRt, D_memWrite;
    logic          X_memRead, X_branchTaken;
    logic          icache_miss, dcache_miss;
    logic          pc_write, IFID_write, IDEX_write, XM_write;
    logic          IFID_flush, IDEX_flush, MW_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl_if mem_if ();

    hazard_stall_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .D_Rs          (D_Rs),
        .D_Rt          (D_Rt),
        .D_usesRs      (D_usesRs),
        .D_usesRt      (D_usesRt),
        .D_memWrite    (D_memWrite),
        .X_memRead     (X_memRead),
        .X_Rd          (X_Rd),
        .X_branchTaken (X_branchTaken),
        .icache_miss   (icache_miss),
        .dcache_miss   (dcache_miss),
        .mem           (mem_if.master),
        .pc_write      (pc_write),
        .IFID_write    (IFID_write),
        .IDEX_write    (IDEX_write),
        .XM_write      (XM_write),
        .IFID_flush    (IFID_flush),
        .IDEX_flush    (IDEX_flush),
        .MW_flush      (MW_flush),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // model: who owns memory (0 none, 1 icache, 2 dcache) and counts
    int m_own   = 0;
    int m_stall = 0;
    int m_flush = 0;

    always @(negedge clk) begin
        bit lu, frozen, fetch_blk;
        bit e_pc, e_ifw, e_idw, e_xmw, e_iff, e_idf, e_mwf, e_req, e_sel;
        lu = X_memRead && (X_Rd != 0) &&
             ((D_usesRs && X_Rd == D_Rs) ||
              (D_usesRt && X_Rd == D_Rt && !D_memWrite));
        frozen    = dcache_miss || (m_own == 2);
        fetch_blk = (m_own == 1) || (m_own == 0 && icache_miss);
        e_pc = 1; e_ifw = 1; e_idw = 1; e_xmw = 1;
        e_iff = 0; e_idf = 0; e_mwf = 0;
        e_req = (m_own != 0);
        e_sel = (m_own == 2);
        if (rst) begin
            e_pc = 0; e_ifw = 0; e_idw = 0; e_xmw = 0;
            e_iff = 1; e_idf = 1; e_mwf = 1;
            e_req = 0; e_sel = 0;
        end else if (frozen) begin
            e_pc = 0; e_ifw = 0; e_idw = 0; e_xmw = 0; e_mwf = 1;
        end else if (X_branchTaken) begin
            e_iff = 1; e_idf = 1;
        end else if (m_own == 0 && lu) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
        end else if (fetch_blk) begin
            e_pc = 0; e_iff = 1;
        end
        chk("m_pc_write", pc_write, e_pc);
        chk("m_IFID_write", IFID_write, e_ifw);
        chk("m_IDEX_write", IDEX_write, e_idw);
        chk("m_XM_write", XM_write, e_xmw);
        chk("m_IFID_flush", IFID_flush, e_iff);
        chk("m_IDEX_flush", IDEX_flush, e_idf);
        chk("m_MW_flush", MW_flush, e_mwf);
        chk("m_fill_req", mem_if.fill_req, e_req);
        chk("m_fill_sel", mem_if.fill_sel, e_sel);
        chk("m_stall_cnt", stall_cnt, m_stall);
        chk("m_flush_cnt", flush_cnt, m_flush);
        if (rst) begin
            m_own = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc) m_stall = (m_stall == SAT) ? SAT : m_stall + 1;
            if (e_iff || e_idf) m_flush = (m_flush == SAT) ? SAT : m_flush + 1;
            case (m_own)
                0: m_own = dcache_miss ? 2 : (icache_miss ? 1 : 0);
                1: if (mem_if.fill_done) m_own = dcache_miss ? 2 : 0;
                default: if (mem_if.fill_done) m_own = icache_miss ? 1 : 0;
            endcase
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_Rs = 0; D_Rt = 0; X_Rd = 0;
        D_usesRs = 0; D_usesRt = 0; D_memWrite = 0;
        X_memRead = 0; X_branchTaken = 0;
        icache_miss = 0; dcache_miss = 0;
        mem_if.fill_done = 0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1;
        idle();
        nxt();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        chk("rst_pc", pc_write, 0);
        chk("rst_req", mem_if.fill_req, 0);
        chk("rst_sel", mem_if.fill_sel, 0);
        chk("rst_mwf", MW_flush, 1);
        chk("rst_idf", IDEX_flush, 1);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("idle_pc", pc_write, 1);
        chk("rst_scnt", stall_cnt, 0);

        // load-use on Rs
        nxt();
        X_memRead = 1; X_Rd = 3; D_Rs = 3; D_usesRs = 1;
        @(negedge clk);
        chk("lu_pc", pc_write, 0);
        chk("lu_ifw", IFID_write, 0);
        chk("lu_idf", IDEX_flush, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("lu_after_pc", pc_write, 1);
        chk("lu_scnt", stall_cnt, 1);

        // store data on Rt is exempt
        nxt();
        X_memRead = 1; X_Rd = 5; D_Rt = 5; D_usesRt = 1; D_memWrite = 1;
        @(negedge clk);
        chk("st_pc", pc_write, 1);
        // R0 never stalls
        nxt();
        idle();
        X_memRead = 1; X_Rd = 0; D_Rs = 0; D_usesRs = 1;
        @(negedge clk);
        chk("r0_pc", pc_write, 1);
        // non-store Rt match stalls
        nxt();
        idle();
        X_memRead = 1; X_Rd = 5; D_Rt = 5; D_usesRt = 1;
        @(negedge clk);
        chk("rt_pc", pc_write, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("rt_scnt", stall_cnt, 2);

        // taken branch masks load-use
        do_reset();
        X_memRead = 1; X_Rd = 3; D_Rs = 3; D_usesRs = 1; X_branchTaken = 1;
        @(negedge clk);
        chk("br_pc", pc_write, 1);
        chk("br_iff", IFID_flush, 1);
        chk("br_idf", IDEX_flush, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("br_fcnt", flush_cnt, 1);
        chk("br_scnt", stall_cnt, 0);

        // dual miss: D first then I
        do_reset();
        icache_miss = 1; dcache_miss = 1;
        @(negedge clk);
        chk("dm_pc", pc_write, 0);
        chk("dm_xmw", XM_write, 0);
        chk("dm_mwf", MW_flush, 1);
        chk("dm_req0", mem_if.fill_req, 0);
        nxt();
        @(negedge clk);
        chk("df_req", mem_if.fill_req, 1);
        chk("df_sel", mem_if.fill_sel, 1);
        nxt();
        nxt();
        mem_if.fill_done = 1;
        @(negedge clk);
        chk("df_done_req", mem_if.fill_req, 1);
        chk("df_done_ifw", IFID_write, 0);
        nxt();
        mem_if.fill_done = 0; dcache_miss = 0;
        @(negedge clk);
        chk("if_req", mem_if.fill_req, 1);
        chk("if_sel", mem_if.fill_sel, 0);
        chk("if_pc", pc_write, 0);
        chk("if_iff", IFID_flush, 1);
        chk("if_xmw", XM_write, 1);
        nxt();
        mem_if.fill_done = 1;
        @(negedge clk);
        chk("if_done_req", mem_if.fill_req, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("dm_end_req", mem_if.fill_req, 0);
        chk("dm_end_pc", pc_write, 1);

        // branch during an I fill
        do_reset();
        icache_miss = 1;
        @(negedge clk);
        chk("ib_run_pc", pc_write, 0);
        chk("ib_run_iff", IFID_flush, 1);
        nxt();
        X_branchTaken = 1;
        @(negedge clk);
        chk("ib_pc", pc_write, 1);
        chk("ib_req", mem_if.fill_req, 1);
        chk("ib_idf", IDEX_flush, 1);
        nxt();
        X_branchTaken = 0;
        @(negedge clk);
        chk("ib_hold_req", mem_if.fill_req, 1);
        chk("ib_hold_pc", pc_write, 0);
        nxt();
        mem_if.fill_done = 1;
        nxt();
        idle();
        @(negedge clk);
        chk("ib_end_req", mem_if.fill_req, 0);

        // reset in third cycle of a D fill
        do_reset();
        dcache_miss = 1;
        nxt();
        nxt();
        nxt();
        rst = 1;
        @(negedge clk);
        chk("rd_req", mem_if.fill_req, 0);
        chk("rd_pc", pc_write, 0);
        chk("rd_iff", IFID_flush, 1);
        nxt();
        rst = 0;
        dcache_miss = 0;
        @(negedge clk);
        chk("rd_after_req", mem_if.fill_req, 0);
        chk("rd_after_pc", pc_write, 1);
        chk("rd_scnt", stall_cnt, 0);
        chk("rd_fcnt", flush_cnt, 0);

        // saturation: 21 stalled cycles on a 4-bit counter
        do_reset();
        icache_miss = 1;
        repeat (19) nxt();
        @(negedge clk);
        chk("sat_mid", stall_cnt, 15);
        nxt();
        mem_if.fill_done = 1;
        nxt();
        idle();
        @(negedge clk);
        chk("sat_scnt", stall_cnt, 15);
        chk("sat_fcnt", flush_cnt, 15);

        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
